// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
package seg_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam logic [7:0] SEG_DARK = 8'h00;
  localparam int         DIG_W    = 4;
endpackage

// File: rtl/seven_seg_mux.sv
// Hex digit to 7-segment decoder, active-high segments {g,f,e,d,c,b,a}; bit 7 tied low.
module seven_seg_mux
  import seg_pkg::*;
(
  input  logic [DIG_W-1:0] val,
  output logic [7:0]       seg_val
);
  always_comb begin
    seg_val = SEG_DARK;
    case (val)
      4'h0: seg_val = 8'h3F;
      4'h1: seg_val = 8'h06;
      4'h2: seg_val = 8'h5B;
      4'h3: seg_val = 8'h4F;
      4'h4: seg_val = 8'h66;
      4'h5: seg_val = 8'h6D;
      4'h6: seg_val = 8'h7D;
      4'h7: seg_val = 8'h07;
      4'h8: seg_val = 8'h7F;
      4'h9: seg_val = 8'h6F;
      4'hA: seg_val = 8'h77;
      4'hB: seg_val = 8'h7C;
      4'hC: seg_val = 8'h39;
      4'hD: seg_val = 8'h5E;
      4'hE: seg_val = 8'h79;
      4'hF: seg_val = 8'h71;
      default: seg_val = SEG_DARK;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed multi-digit 7-segment scan controller with per-frame snapshot,
// ghost-suppression blanking, decimal points and optional leading-zero blanking.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [DIG_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic                        lz_blank,
  output logic [NUM_DIGITS-1:0]       dig_sel,
  output logic [7:0]                  seg_out,
  output logic                        frame_start
);
  localparam int CW          = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IW          = $clog2(NUM_DIGITS);
  localparam int SHOW_CYCLES = SLOT_CYCLES - BLANK_CYCLES;

  state_e                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [DIG_W*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]       dp_snap_q, dp_snap_d;
  logic [NUM_DIGITS-1:0]       lz_mask_q, lz_mask_d;
  logic [NUM_DIGITS-1:0]       dig_sel_q, dig_sel_d;
  logic [7:0]                  seg_q, seg_d;
  logic                        fs_q, fs_d;
  logic                        capture;
  logic [DIG_W-1:0]            mux_val;
  logic [7:0]                  seg_val;

  // Digit i>0 is dark when it and every more-significant digit are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask_f(
    input logic [DIG_W*NUM_DIGITS-1:0] d,
    input logic                        lz
  );
    logic [NUM_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (d[DIG_W*i +: DIG_W] == '0);
      mask[i]  = all_zero & lz;
    end
    return mask;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    fs_d    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_SHOW;
      idx_d   = '0;
      cnt_d   = '0;
      capture = 1'b1;
      fs_d    = 1'b1;
    end else if (cnt_q == CW'(SLOT_CYCLES - 1)) begin
      cnt_d   = '0;
      state_d = ST_SHOW;
      if (idx_q == IW'(NUM_DIGITS - 1)) begin
        idx_d   = '0;
        capture = 1'b1;
        fs_d    = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (int'(cnt_q) + 1 >= SHOW_CYCLES) ? ST_BLANK : ST_SHOW;
    end
  end

  always_comb begin
    snap_d    = capture ? digits_in : snap_q;
    dp_snap_d = capture ? dp_in : dp_snap_q;
    lz_mask_d = capture ? lz_mask_f(digits_in, lz_blank) : lz_mask_q;
    mux_val   = snap_d[DIG_W*idx_d +: DIG_W];
  end

  seven_seg_mux u_dec (
    .val     (mux_val),
    .seg_val (seg_val)
  );

  // Outputs are built from next-state values so select and segments land on the same edge.
  always_comb begin
    dig_sel_d = '0;
    seg_d     = SEG_DARK;
    if (state_d == ST_SHOW) begin
      dig_sel_d = NUM_DIGITS'(1) << idx_d;
      if (lz_mask_d[idx_d]) seg_d = {dp_snap_d[idx_d], 7'b0};
      else                  seg_d = seg_val | {dp_snap_d[idx_d], 7'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      dp_snap_q <= '0;
      lz_mask_q <= '0;
      dig_sel_q <= '0;
      seg_q     <= SEG_DARK;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      dp_snap_q <= dp_snap_d;
      lz_mask_q <= lz_mask_d;
      dig_sel_q <= dig_sel_d;
      seg_q     <= seg_d;
      fs_q      <= fs_d;
    end
  end

  assign dig_sel     = dig_sel_q;
  assign seg_out     = seg_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: scan order, snapshot, lz blanking, enable and reset.
module tb_seven_seg_scan_ctrl;
  localparam int N = 4;
  localparam int S = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst, en, en_nb, lz_blank;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  dig_sel, dig_sel_nb;
  logic [7:0]  seg_out, seg_out_nb;
  logic        frame_start, frame_start_nb;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .dig_sel(dig_sel), .seg_out(seg_out), .frame_start(frame_start)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .BLANK_CYCLES(0)) dut_nb (
    .clk(clk), .rst(rst), .en(en_nb), .digits_in(digits_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .dig_sel(dig_sel_nb), .seg_out(seg_out_nb),
    .frame_start(frame_start_nb)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [15:0] dg, input logic [3:0] dp,
                                         input logic lz, input int d);
    logic [3:0] v;
    v = dg[4*d +: 4];
    if (lz && d != 0 && (dg >> (4*d)) == 16'h0) return {dp[d], 7'h00};
    return {dp[d], dec7(v)};
  endfunction

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; en_nb = 1'b0; lz_blank = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
    step; step;
    checks++;
    if ({dig_sel, seg_out, frame_start} !== 13'h0) begin
      errors++;
      $display("FAIL reset_state: dig_sel=%b seg=%h fs=%b, want 0/00/0", dig_sel, seg_out, frame_start);
    end
    rst = 1'b0; digits_in = 16'h1234; en = 1'b1;
    step; step; step;
    checks++;
    if (dig_sel !== 4'b0001 || seg_out !== 8'h66) begin
      errors++;
      $display("FAIL pre_reset_show: dig_sel=%b seg=%h, want 0001/66", dig_sel, seg_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dig_sel, seg_out, frame_start} !== 13'h0) begin
      errors++;
      $display("FAIL async_reset: dig_sel=%b seg=%h fs=%b, want 0/00/0", dig_sel, seg_out, frame_start);
    end
    en = 1'b0;
    step;
    rst = 1'b0;
    step;
    checks++;
    if ({dig_sel, seg_out, frame_start} !== 13'h0) begin
      errors++;
      $display("FAIL idle_after_reset: dig_sel=%b seg=%h fs=%b, want 0/00/0", dig_sel, seg_out, frame_start);
    end
  endtask

  task automatic test_basic_scan;
    logic [3:0] esel;
    logic [7:0] eseg;
    digits_in = 16'h1234; dp_in = 4'b0100; lz_blank = 1'b0; en = 1'b1;
    step;
    for (int k = 0; k < 32; k++) begin
      esel = (k % 8 < S - B) ? 4'(1 << (k / 8)) : 4'h0;
      eseg = (k % 8 < S - B) ? exp_seg(16'h1234, 4'b0100, 1'b0, k / 8) : 8'h00;
      checks++;
      if ({dig_sel, seg_out, frame_start} !== {esel, eseg, (k == 0)}) begin
        errors++;
        $display("FAIL basic_scan k=%0d: dig_sel=%b seg=%h fs=%b, want %b/%h/%b",
                 k, dig_sel, seg_out, frame_start, esel, eseg, (k == 0));
      end
      step;
    end
    checks++;
    if (frame_start !== 1'b1 || dig_sel !== 4'b0001) begin
      errors++;
      $display("FAIL frame_period: fs=%b dig_sel=%b at cycle 32, want 1/0001", frame_start, dig_sel);
    end
  endtask

  task automatic test_snapshot;
    logic [3:0]  esel;
    logic [7:0]  eseg;
    logic [15:0] ed;
    for (int k = 0; k < 64; k++) begin
      ed   = (k < 32) ? 16'h1234 : 16'h5678;
      esel = (k % 8 < S - B) ? 4'(1 << ((k % 32) / 8)) : 4'h0;
      eseg = (k % 8 < S - B) ? exp_seg(ed, 4'b0100, 1'b0, (k % 32) / 8) : 8'h00;
      checks++;
      if ({dig_sel, seg_out, frame_start} !== {esel, eseg, (k % 32 == 0)}) begin
        errors++;
        $display("FAIL snapshot k=%0d: dig_sel=%b seg=%h fs=%b, want %b/%h/%b",
                 k, dig_sel, seg_out, frame_start, esel, eseg, (k % 32 == 0));
      end
      if (k == 17) digits_in = 16'h5678;
      step;
    end
  endtask

  task automatic test_lz_blank;
    logic [3:0]  esel;
    logic [7:0]  eseg;
    logic [15:0] dg_tab [2];
    logic [3:0]  dp_tab [2];
    dg_tab[0] = 16'h0050; dp_tab[0] = 4'b1000;
    dg_tab[1] = 16'h0000; dp_tab[1] = 4'b0010;
    for (int t = 0; t < 2; t++) begin
      en = 1'b0;
      step;
      lz_blank = 1'b1; digits_in = dg_tab[t]; dp_in = dp_tab[t]; en = 1'b1;
      step;
      for (int k = 0; k < 32; k++) begin
        esel = (k % 8 < S - B) ? 4'(1 << (k / 8)) : 4'h0;
        eseg = (k % 8 < S - B) ? exp_seg(dg_tab[t], dp_tab[t], 1'b1, k / 8) : 8'h00;
        checks++;
        if ({dig_sel, seg_out} !== {esel, eseg}) begin
          errors++;
          $display("FAIL lz_blank t=%0d k=%0d: dig_sel=%b seg=%h, want %b/%h",
                   t, k, dig_sel, seg_out, esel, eseg);
        end
        step;
      end
    end
  endtask

  task automatic test_en_drop;
    logic [3:0] esel;
    logic [7:0] eseg;
    en = 1'b0;
    step;
    lz_blank = 1'b0; digits_in = 16'h1234; dp_in = 4'b0100; en = 1'b1;
    step;
    for (int k = 0; k <= 14; k++) begin
      esel = (k % 8 < S - B) ? 4'(1 << (k / 8)) : 4'h0;
      eseg = (k % 8 < S - B) ? exp_seg(16'h1234, 4'b0100, 1'b0, k / 8) : 8'h00;
      checks++;
      if ({dig_sel, seg_out} !== {esel, eseg}) begin
        errors++;
        $display("FAIL en_drop_pre k=%0d: dig_sel=%b seg=%h, want %b/%h", k, dig_sel, seg_out, esel, eseg);
      end
      if (k < 14) step;
    end
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step;
      checks++;
      if ({dig_sel, seg_out, frame_start} !== 13'h0) begin
        errors++;
        $display("FAIL en_drop_idle c=%0d: dig_sel=%b seg=%h fs=%b, want 0/00/0",
                 c, dig_sel, seg_out, frame_start);
      end
    end
    digits_in = 16'h5678; en = 1'b1;
    step;
    checks++;
    if ({dig_sel, seg_out, frame_start} !== {4'b0001, 8'h7F, 1'b1}) begin
      errors++;
      $display("FAIL en_restart: dig_sel=%b seg=%h fs=%b, want 0001/7f/1", dig_sel, seg_out, frame_start);
    end
    step;
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL en_restart_pulse: fs=%b, want 0", frame_start);
    end
  endtask

  task automatic test_no_blank;
    logic [3:0] esel;
    logic [7:0] eseg;
    en = 1'b0;
    step;
    digits_in = 16'h1234; dp_in = 4'b0100; lz_blank = 1'b0; en_nb = 1'b1;
    step;
    for (int k = 0; k < 32; k++) begin
      esel = 4'(1 << (k / 8));
      eseg = exp_seg(16'h1234, 4'b0100, 1'b0, k / 8);
      checks++;
      if ({dig_sel_nb, seg_out_nb, frame_start_nb} !== {esel, eseg, (k == 0)}) begin
        errors++;
        $display("FAIL no_blank k=%0d: dig_sel=%b seg=%h fs=%b, want %b/%h/%b",
                 k, dig_sel_nb, seg_out_nb, frame_start_nb, esel, eseg, (k == 0));
      end
      step;
    end
    checks++;
    if (frame_start_nb !== 1'b1 || dig_sel_nb !== 4'b0001) begin
      errors++;
      $display("FAIL no_blank_period: fs=%b dig_sel=%b at cycle 32, want 1/0001",
               frame_start_nb, dig_sel_nb);
    end
  endtask

  initial begin
    test_reset;
    test_basic_scan;
    test_snapshot;
    test_lz_blank;
    test_en_drop;
    test_no_blank;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
